cond_logic_mt: RTL and testbench
================================

# cond_logic_mt

Multi-thread conditional-execution unit for the processor control path, the parametrised successor of the single-flag-set condition logic. It holds one NZCV flag bank per hardware thread and evaluates the 4-bit ARM condition field against the issuing thread's flags. It adds a per-thread predicated-block mode: a prefix instruction places up to BLOCK_MAX following instructions under a shared condition. It gates PCSrc, RegWrite and MemWrite exactly as the existing decoder/datapath expect.

## Interface
- THREADS, 2, number of hardware threads / flag banks (≥1)
- TID_W, 1, thread-ID width, ≥ clog2(THREADS), minimum 1
- BLOCK_MAX, 4, maximum predicated-block length (≥1)
- CNT_W, 3, block-counter width, must hold BLOCK_MAX

- clk  in  1  rising-edge clock; one clock only
- reset  in  1  asynchronous, active-low; clears all state immediately
- Valid  in  1  instruction present this cycle
- Tid  in  TID_W  issuing thread; values ≥ THREADS are treated as Valid=0
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- FlagW  in  2  [1] = write N,Z; [0] = write C,V
- PCS, RegW, MemW, NoWrite  in  1 each  decoder controls
- BlkStart  in  1  instruction is a block prefix
- BlkLen  in  CNT_W  number of following instructions in the block
- CondEx  out  1  instruction executes
- PCSrc, RegWrite, MemWrite  out  1 each  gated controls
- Flags  out  4  current NZCV of bank Tid
- BlkActive  out  1  thread Tid is in block mode

## Operation
- Flag bank per thread: NZCV, reset 0000. Bits N,Z are written when FlagWrite[1] = FlagW[1] & CondEx & Valid. Bits C,V are written when FlagWrite[0] = FlagW[0] & CondEx & Valid. Writes take effect at the posedge.
- Condition eval(c, NZCV):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
- Per-thread block FSM, states IDLE and ACTIVE, with registers bcond[3:0] and bcnt[CNT_W-1:0]. Reset state: IDLE, bcond 0, bcnt 0.
- In IDLE:
  - A prefix (Valid & BlkStart) produces CondEx=0 and all gated outputs 0, and writes no flags.
  - The prefix captures bcond=Cond and bcnt=min(BlkLen, BLOCK_MAX).
  - If BlkLen=0, the prefix is a no-op and the FSM stays IDLE.
  - Otherwise the FSM goes to ACTIVE at the next edge.
- In ACTIVE, for each Valid instruction of that thread:
  - CondEx = eval(Cond) & eval(bcond), both evaluated against the current (pre-edge) flags.
  - bcnt decrements; when bcnt=1 the FSM returns to IDLE after that instruction.
  - A BlkStart seen while ACTIVE counts as a member with CondEx forced to 0. It captures nothing and still decrements bcnt.
  - A taken branch (PCS & CondEx) forces IDLE and bcnt=0 at the edge.
  - Flag writes by block members affect later members.
- Gated outputs:
  - PCSrc = PCS & CondEx
  - MemWrite = MemW & CondEx
  - RegWrite = RegW & !NoWrite & CondEx
- Valid=0 (or Tid out of range): CondEx and all gated outputs are 0, and no state changes.
- Threads are fully independent. An instruction of thread A never alters thread B's flags or FSM.

## Timing
- CondEx, PCSrc, RegWrite, MemWrite, Flags and BlkActive are combinational from inputs and current state; there is zero-cycle latency.
- Flag and FSM updates occur at the posedge of clk. Flags reflects the new value in the following cycle; there is no write-to-read bypass.
- Asserting reset at any time, including mid-block, immediately clears every bank to 0000 and every FSM to IDLE. All outputs then read 0: Flags=0000, BlkActive=0, gated outputs 0.
- Only one instruction can be accepted per cycle; there is no back-pressure.

## Test plan
- Reset, then AL with FlagW=11, ALUFlags=0100 on thread 0 -> CondEx=1. Next cycle Flags=0100; Cond=0000 (EQ) -> CondEx=1; Cond=0001 (NE) -> CondEx=0, RegWrite=0.
- Write thread 0 flags to 1000 (N), then issue GE on thread 1 -> thread 1 Flags=0000 and CondEx=1; the same GE on thread 0 -> CondEx=0.
- Prefix with Cond=EQ, BlkLen=3 and Z=1, then three AL instructions with RegW=1 -> RegWrite=1 on all three. BlkActive=1 during the block, 0 after the third.
- Block with Cond=NE, BlkLen=2 and Z=0. The first member has FlagW=10 with ALUFlags Z=1 -> executes and sets Z. The second member -> CondEx=0.
- BlkLen=7 with BLOCK_MAX=4 -> exactly 4 members are predicated. A taken branch as member 2 -> BlkActive=0 next cycle.
- Assert reset mid-block after member 1 -> BlkActive=0 and Flags=0000 immediately. Cond=1111 -> CondEx=0 regardless of flags.

Source files
------------

// File: rtl/cond_logic_mt.sv
// Multi-thread conditional-execution unit: one NZCV bank and one predicated-block
// FSM per hardware thread, gating PCSrc/RegWrite/MemWrite for the issuing thread.
module cond_logic_mt #(
  parameter int THREADS   = 2,
  parameter int TID_W     = 1,
  parameter int BLOCK_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [TID_W-1:0] Tid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             BlkStart,
  input  logic [CNT_W-1:0] BlkLen,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             BlkActive
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] BMAX = CNT_W'(BLOCK_MAX);

  logic [3:0]       flags_q [THREADS];
  state_t           st_q    [THREADS];
  logic [3:0]       bcond_q [THREADS];
  logic [CNT_W-1:0] bcnt_q  [THREADS];

  logic [THREADS-1:0] sel;
  logic [3:0]         cur_flags;
  logic [3:0]         cur_bcond;
  logic               cur_active;
  logic               vld;
  logic               cond_ok;
  logic               blk_ok;
  logic [CNT_W-1:0]   blk_len_sat;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = !z;
      4'b0010: eval_cond = cy;
      4'b0011: eval_cond = !cy;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = !n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = !v;
      4'b1000: eval_cond = cy & !z;
      4'b1001: eval_cond = !cy | z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = !z & (n == v);
      4'b1101: eval_cond = z | (n != v);
      4'b1110: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Select the issuing thread's state; an out-of-range Tid matches no bank.
  always_comb begin
    sel        = '0;
    cur_flags  = 4'b0000;
    cur_bcond  = 4'b0000;
    cur_active = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      sel[t] = (Tid == TID_W'(t));
      if (sel[t]) begin
        cur_flags  = flags_q[t];
        cur_bcond  = bcond_q[t];
        cur_active = (st_q[t] == ACTIVE);
      end
    end
  end

  // Holding reset low also forces every gated output low.
  assign vld         = Valid & reset & (|sel);
  assign cond_ok     = eval_cond(Cond, cur_flags);
  assign blk_ok      = eval_cond(cur_bcond, cur_flags);
  assign blk_len_sat = (BlkLen > BMAX) ? BMAX : BlkLen;

  always_comb begin
    CondEx = 1'b0;
    if (vld && !BlkStart)
      CondEx = cur_active ? (cond_ok & blk_ok) : cond_ok;
  end

  assign PCSrc     = PCS & CondEx;
  assign MemWrite  = MemW & CondEx;
  assign RegWrite  = RegW & !NoWrite & CondEx;
  assign Flags     = cur_flags;
  assign BlkActive = cur_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < THREADS; t++) begin
        flags_q[t] <= 4'b0000;
        st_q[t]    <= IDLE;
        bcond_q[t] <= 4'b0000;
        bcnt_q[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (vld && sel[t]) begin
          if (FlagW[1] && CondEx) flags_q[t][3:2] <= ALUFlags[3:2];
          if (FlagW[0] && CondEx) flags_q[t][1:0] <= ALUFlags[1:0];
          case (st_q[t])
            IDLE: begin
              if (BlkStart) begin
                bcond_q[t] <= Cond;
                bcnt_q[t]  <= blk_len_sat;
                if (BlkLen != '0) st_q[t] <= ACTIVE;
              end
            end
            default: begin
              if (PCS && CondEx) begin
                st_q[t]   <= IDLE;
                bcnt_q[t] <= '0;
              end else begin
                bcnt_q[t] <= bcnt_q[t] - CNT_W'(1);
                if (bcnt_q[t] == CNT_W'(1)) st_q[t] <= IDLE;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_logic_mt.sv
// Directed bench for cond_logic_mt: flag banks, condition codes, thread
// isolation, predicated blocks, block truncation, branch exit and async reset.
module tb_cond_logic_mt;

  logic       clk = 1'b0;
  logic       reset;
  logic       Valid;
  logic [0:0] Tid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, BlkStart;
  logic [2:0] BlkLen;
  logic       CondEx, PCSrc, RegWrite, MemWrite, BlkActive;
  logic [3:0] Flags;

  int n_cmp = 0;
  int n_err = 0;

  cond_logic_mt #(.THREADS(2), .TID_W(1), .BLOCK_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Tid(Tid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .BlkStart(BlkStart), .BlkLen(BlkLen),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .BlkActive(BlkActive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic t, input logic [3:0] c, input logic [3:0] af,
                     input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                     input logic nw, input logic bs, input logic [2:0] bl);
    Valid = v; Tid = t; Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs;
    RegW = rw; MemW = mw; NoWrite = nw; BlkStart = bs; BlkLen = bl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic t);
    drv(1'b0, t, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    reset = 1'b0;
    drv(1'b0, 1'b0, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_blkactive", BlkActive, 4'h0);
    chk("rst_condex", CondEx, 4'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // AL writes NZCV=0100 on thread 0
    drv(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 3'd0);
    chk("al_condex", CondEx, 4'h1);
    chk("flags_before_edge", Flags, 4'h0);
    tick();
    drv(1, 0, 4'b0000, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("t0_flags_0100", Flags, 4'b0100);
    chk("eq_condex", CondEx, 4'h1);
    chk("eq_regwrite", RegWrite, 4'h1);
    tick();
    drv(1, 0, 4'b0001, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("ne_condex", CondEx, 4'h0);
    chk("ne_regwrite", RegWrite, 4'h0);
    tick();

    // Thread isolation: t0 gets N, t1 stays 0000
    drv(1, 0, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 1, 4'b1010, 4'h0, 2'b00, 0, 0, 1, 0, 0, 3'd0);
    chk("t1_flags", Flags, 4'h0);
    chk("t1_ge_condex", CondEx, 4'h1);
    chk("t1_ge_memwrite", MemWrite, 4'h1);
    tick();
    drv(1, 0, 4'b1010, 4'h0, 2'b00, 0, 0, 1, 0, 0, 3'd0);
    chk("t0_flags_1000", Flags, 4'b1000);
    chk("t0_ge_condex", CondEx, 4'h0);
    chk("t0_ge_memwrite", MemWrite, 4'h0);
    tick();
    drv(1, 1, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 1, 0, 3'd0);
    chk("nowrite_condex", CondEx, 4'h1);
    chk("nowrite_regwrite", RegWrite, 4'h0);
    tick();
    drv(1, 0, 4'b1101, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    chk("t0_le_condex", CondEx, 4'h1);
    tick();

    // Block EQ len 3 with Z=1, interleaved with a thread-1 instruction
    drv(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 0, 4'b0000, 4'h0, 2'b00, 1, 1, 1, 0, 1, 3'd3);
    chk("pfx_condex", CondEx, 4'h0);
    chk("pfx_pcsrc", PCSrc, 4'h0);
    chk("pfx_regwrite", RegWrite, 4'h0);
    chk("pfx_blkactive", BlkActive, 4'h0);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b1_m1_active", BlkActive, 4'h1);
    chk("b1_m1_regwrite", RegWrite, 4'h1);
    tick();
    drv(1, 1, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b1_t1_active", BlkActive, 4'h0);
    chk("b1_t1_condex", CondEx, 4'h1);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b1_m2_active", BlkActive, 4'h1);
    chk("b1_m2_regwrite", RegWrite, 4'h1);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b1_m3_active", BlkActive, 4'h1);
    chk("b1_m3_regwrite", RegWrite, 4'h1);
    tick();
    idle(0);
    chk("b1_after_active", BlkActive, 4'h0);

    // Block NE len 2: member 1 sets Z, member 2 is then squashed
    drv(1, 0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 0, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd2);
    tick();
    drv(1, 0, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0, 0, 3'd0);
    chk("b2_m1_condex", CondEx, 4'h1);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b2_flags", Flags, 4'b0100);
    chk("b2_m2_active", BlkActive, 4'h1);
    chk("b2_m2_condex", CondEx, 4'h0);
    chk("b2_m2_regwrite", RegWrite, 4'h0);
    tick();
    idle(0);
    chk("b2_after_active", BlkActive, 4'h0);

    // BlkLen=7 saturates at 4: NE block with Z=1 squashes exactly 4 members
    drv(1, 0, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
      chk($sformatf("b3_m%0d_active", i + 1), BlkActive, 4'h1);
      chk($sformatf("b3_m%0d_condex", i + 1), CondEx, 4'h0);
      tick();
    end
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b3_m5_active", BlkActive, 4'h0);
    chk("b3_m5_condex", CondEx, 4'h1);
    tick();

    // Taken branch as member 2 ends the block
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd3);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 0, 3'd0);
    chk("b4_br_pcsrc", PCSrc, 4'h1);
    chk("b4_br_active", BlkActive, 4'h1);
    tick();
    idle(0);
    chk("b4_after_br_active", BlkActive, 4'h0);
    tick();

    // BlkStart inside a block: squashed member, no capture, still counted
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd2);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 1, 3'd4);
    chk("b5_nested_condex", CondEx, 4'h0);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0, 3'd0);
    chk("b5_m2_active", BlkActive, 4'h1);
    chk("b5_m2_regwrite", RegWrite, 4'h1);
    tick();
    idle(0);
    chk("b5_after_active", BlkActive, 4'h0);

    // BlkLen=0 prefix is a no-op
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd0);
    chk("len0_condex", CondEx, 4'h0);
    tick();
    idle(0);
    chk("len0_active", BlkActive, 4'h0);

    // Reset mid-block
    drv(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 0, 4'b1111, 4'h0, 2'b00, 1, 1, 1, 0, 0, 3'd0);
    chk("nv_flags", Flags, 4'b1111);
    chk("nv_condex", CondEx, 4'h0);
    chk("nv_pcsrc", PCSrc, 4'h0);
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1, 3'd3);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    tick();
    drv(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 1, 0, 0, 3'd0);
    chk("pre_rst_active", BlkActive, 4'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_active", BlkActive, 4'h0);
    chk("mid_rst_flags", Flags, 4'h0);
    chk("mid_rst_condex", CondEx, 4'h0);
    chk("mid_rst_regwrite", RegWrite, 4'h0);
    chk("mid_rst_memwrite", MemWrite, 4'h0);
    tick();
    reset = 1'b1;
    drv(1, 0, 4'b1111, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    chk("post_rst_nv_condex", CondEx, 4'h0);
    drv(1, 0, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3'd0);
    chk("post_rst_ne_condex", CondEx, 4'h1);
    chk("post_rst_active", BlkActive, 4'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
